// File: rtl/bitstream_word_loader_pkg.sv
// Shared definitions for the bitstream word loader: FSM state encoding,
// default pacing constants, and the sync word that test images start with.
// Imported by the loader top, its byte packer and the bench.
package bitstream_word_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } loader_state_t;

  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES  = 2;

  // FETCH always spans 4 read slots plus one cycle for the last byte to return
  localparam int FETCH_CYCLES = 5;

  // Width of the in-state cycle counter shared by FETCH/SETUP/HOLD
  localparam int CNT_W = 8;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/bitstream_word_loader_if.sv
// Memory read port and fabric self-write port of the bitstream word loader.
// master = loader side, slave = memory/fabric side.
// No handshake: memory returns data one cycle after a read, fabric takes the strobe.
interface bitstream_word_loader_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic [31:0]       SelfWriteData;
  logic              SelfWriteStrobe;

  modport master (
    output mem_addr, mem_rd_en, SelfWriteData, SelfWriteStrobe,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, SelfWriteData, SelfWriteStrobe,
    output mem_rdata
  );
endinterface

// File: rtl/bitstream_word_loader_packer.sv
// Byte packer: issues up to 4 byte reads per word and assembles them big-endian.
// Latency: byte k lands one cycle after its read; full word visible on slot 4.
// No backpressure: reads past the image length are suppressed and pad with 0x00.
module bitstream_byte_packer #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [2:0]        slot,
  input  logic [ADDR_W:0]   base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic [31:0]       word
);

  logic [ADDR_W:0] byte_idx;
  logic            pend_vld;
  logic [1:0]      pend_lane;
  logic [31:0]     word_buf;

  // Read slots 0..3 address base..base+3; anything at or past len is not read
  always_comb begin
    byte_idx = base + (ADDR_W+1)'(slot);
    rd_en    = fetch && (slot < 3'd4) && (byte_idx < len);
    rd_addr  = rd_en ? byte_idx[ADDR_W-1:0] : '0;
  end

  // Track which lane the in-flight read belongs to and accumulate the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_lane <= 2'd0;
      word_buf  <= '0;
    end else begin
      pend_vld  <= rd_en;
      pend_lane <= slot[1:0];
      if (fetch && slot == 3'd0) begin
        word_buf <= '0;
      end else if (pend_vld) begin
        word_buf <= word;
      end
    end
  end

  // Merge the byte returning this cycle so the caller sees the full word on slot 4
  always_comb begin
    word = word_buf;
    if (pend_vld) begin
      case (pend_lane)
        2'd0:    word[31:24] = rd_data;
        2'd1:    word[23:16] = rd_data;
        2'd2:    word[15:8]  = rd_data;
        default: word[7:0]   = rd_data;
      endcase
    end
  end

endmodule

// File: rtl/bitstream_word_loader.sv
// Loads a byte bitstream from sync memory and writes it to the fabric as 32-bit words.
// Latency: 5 + SETUP_CYCLES + 1 + HOLD_CYCLES cycles per word; done one cycle after last HOLD.
// No backpressure; start is ignored while busy. LOADER_CHECKSUM_EN adds the checksum port.
module bitstream_word_loader
  import bitstream_word_loader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W:0]         num_bytes,
  bitstream_word_loader_if.master bus,
  output logic                    busy,
  output logic                    done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]             checksum
`endif
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W:0] len, base, base_adv, len_clamped;
  logic            accept;
  logic            word_end;
  logic [31:0]     packed_word;
  logic [31:0]     data;
  logic            strobe;

  assign len_clamped = (num_bytes > MAX_LEN) ? MAX_LEN : num_bytes;
  assign base_adv    = base + (ADDR_W+1)'(4);
  assign accept      = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign word_end    = (state == ST_HOLD) && (cnt == CNT_W'(HOLD_CYCLES - 1));

  bitstream_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk     (CLK),
    .rst     (reset),
    .fetch   (state == ST_FETCH),
    .slot    (cnt[2:0]),
    .base    (base),
    .len     (len),
    .rd_addr (bus.mem_addr),
    .rd_en   (bus.mem_rd_en),
    .rd_data (bus.mem_rdata),
    .word    (packed_word)
  );

  // State register and in-state cycle counter
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts from 0 on every state change
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      ST_IDLE, ST_DONE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = (len_clamped == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cnt == CNT_W'(FETCH_CYCLES - 1)) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = '0;
        end
      end
      ST_STROBE: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
      end
      ST_HOLD: begin
        if (word_end) begin
          state_nxt = (base_adv >= len) ? ST_DONE : ST_FETCH;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered fabric-side outputs and load bookkeeping; strobe/busy/done come
  // straight from flops so they cannot glitch
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      len    <= '0;
      base   <= '0;
      data   <= '0;
      strobe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      strobe <= (state_nxt == ST_STROBE);
      busy   <= (state_nxt == ST_FETCH) || (state_nxt == ST_SETUP) ||
                (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);
      done   <= (state_nxt == ST_DONE);
      if (accept) begin
        len  <= len_clamped;
        base <= '0;
      end else if (word_end) begin
        base <= base_adv;
      end
      if ((state == ST_FETCH) && (cnt == CNT_W'(FETCH_CYCLES - 1))) begin
        data <= packed_word;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every word, folded in during its strobe cycle
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == ST_STROBE) begin
      checksum <= checksum ^ data;
    end
  end
`endif

  assign bus.SelfWriteData   = data;
  assign bus.SelfWriteStrobe = strobe;

endmodule

// File: tb/tb_bitstream_word_loader.sv
// Self-checking bench for bitstream_word_loader with a scoreboard of expected words.
module tb_bitstream_word_loader;
  import bitstream_word_loader_pkg::*;

  localparam int AW  = 6;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_bytes;
  logic          busy;
  logic          done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  bitstream_word_loader_if #(.ADDR_W(AW)) bus ();

  bitstream_word_loader #(.ADDR_W(AW), .SETUP_CYCLES(2), .HOLD_CYCLES(2)) dut (
    .CLK       (clk),
    .reset     (rst),
    .start     (start),
    .num_bytes (num_bytes),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:MEM-1];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] exp_sum;
  int          cur_len = 0;
  int          load_seq = 0;

  // Monitor-owned state
  int          mon_seq = 0;
  int          strobes_in_load = 0;
  int          strobe_total = 0;
  int          cyc = 0;
  int          last_strobe = 0;
  int          hold_left = 0;
  logic [31:0] hold_val = '0;
  logic [31:0] d1 = '0, d2 = '0;

  always @(negedge clk) begin
    cyc++;
    if (mon_seq != load_seq) begin
      mon_seq = load_seq;
      strobes_in_load = 0;
    end
    if (!rst) begin
      if (bus.mem_rd_en)
        chk("addr_range", (int'(bus.mem_addr) < cur_len) ? 32'd1 : 32'd0, 32'd1);
      if (hold_left > 0) begin
        chk("hold", bus.SelfWriteData, hold_val);
        hold_left--;
      end
      if (bus.SelfWriteStrobe) begin
        chk("setup1", d1, bus.SelfWriteData);
        chk("setup2", d2, bus.SelfWriteData);
        if (strobes_in_load > 0) chk("period", 32'(cyc - last_strobe), 32'd10);
        last_strobe = cyc;
        strobes_in_load++;
        strobe_total++;
        if (exp_q.size() == 0) chk("extra_strobe", 32'd1, 32'd0);
        else chk("word", bus.SelfWriteData, exp_q.pop_front());
        hold_left = 2;
        hold_val  = bus.SelfWriteData;
      end
    end
    d2 = d1;
    d1 = bus.SelfWriteData;
  end

  // Drive an accepted start and push the words the bench expects to see
  task automatic start_load(input int nb);
    logic [31:0] w;
    int idx;
    @(posedge clk); #1;
    start = 1'b1;
    num_bytes = nb[AW:0];
    cur_len = (nb > MEM) ? MEM : nb;
    load_seq++;
    exp_sum = '0;
    for (int wi = 0; wi < (cur_len + 3) / 4; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        idx = wi * 4 + k;
        w = {w[23:0], (idx < cur_len) ? mem[idx] : 8'h00};
      end
      exp_q.push_back(w);
      exp_sum ^= w;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'b0, done}, 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, exp_sum);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_strobe"}, {31'b0, bus.SelfWriteStrobe}, 32'd0);
    chk({tag, "_data"}, bus.SelfWriteData, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_rd_en"}, {31'b0, bus.mem_rd_en}, 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    int n;
    rst = 1'b1;
    start = 1'b0;
    num_bytes = '0;
    for (int i = 0; i < MEM; i++) mem[i] = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Zero-length image: done next cycle, no strobes
    snap = strobe_total;
    @(posedge clk); #1;
    start = 1'b1;
    num_bytes = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("zero_strobes", 32'(strobe_total - snap), 32'd0);

    // 8-byte image 00..07
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    start_load(8);
    wait_done(200);
    chk("img8_count", 32'(strobes_in_load), 32'd2);
    chk("img8_last_data", bus.SelfWriteData, 32'h04050607);
`ifdef LOADER_CHECKSUM_EN
    chk("img8_checksum", checksum, 32'h04040404);
`endif

    // 6-byte image AA..AF with tail padding
    for (int i = 0; i < MEM; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 6; i++) mem[i] = 8'hAA + 8'(i);
    start_load(6);
    wait_done(200);
    chk("img6_count", 32'(strobes_in_load), 32'd2);
    chk("img6_last_data", bus.SelfWriteData, 32'hAEAF0000);

    // Start while busy is ignored; start from DONE begins a new load
    for (int i = 0; i < MEM; i++) mem[i] = 8'(i * 3 + 1);
    start_load(12);
    repeat (7) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    num_bytes = 7'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300);
    chk("busy_start_count", 32'(strobes_in_load), 32'd3);
    start_load(4);
    wait_done(200);
    chk("restart_count", 32'(strobes_in_load), 32'd1);

    // Reset during FETCH of the third word, then a clean reload
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem[0] = SYNC_WORD[31:24];
    mem[1] = SYNC_WORD[23:16];
    mem[2] = SYNC_WORD[15:8];
    mem[3] = SYNC_WORD[7:0];
    start_load(16);
    n = 0;
    while (strobes_in_load < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_strobes", 32'(strobes_in_load), 32'd2);
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    snap = strobe_total;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midload_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_no_strobe", 32'(strobe_total - snap), 32'd0);
    rst = 1'b0;
    start_load(16);
    wait_done(300);
    chk("reload_count", 32'(strobes_in_load), 32'd4);

    // Oversized length clamps to the memory size
    for (int i = 0; i < MEM; i++) mem[i] = 8'(i) ^ 8'h5A;
    start_load(100);
    wait_done(400);
    chk("clamp_count", 32'(strobes_in_load), 32'd16);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
